// File: rtl/memory_error_log_register.sv
// Multi-channel ECC event logger: per-channel saturating CE/UE counters,
// first-error address capture, threshold alarms and a registered read port.
module memory_error_log_register #(
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ce_event,
  input  logic [NUM_CH-1:0]            ue_event,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] event_addr,
  input  logic [CNT_WIDTH-1:0]         ce_threshold,
  input  logic                         clear_req,
  input  logic [SEL_WIDTH-1:0]         clear_sel,
  input  logic [NUM_CH-1:0]            irq_ack,
  input  logic [SEL_WIDTH-1:0]         rd_sel,
  output logic [CNT_WIDTH-1:0]         ce_count_out,
  output logic [CNT_WIDTH-1:0]         ue_count_out,
  output logic [ADDR_WIDTH-1:0]        first_addr_out,
  output logic                         first_valid_out,
  output logic                         ce_sat_out,
  output logic [NUM_CH-1:0]            alarm_pending,
  output logic                         irq
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [CNT_WIDTH-1:0]  ceCntAll  [NUM_CH];
  logic [CNT_WIDTH-1:0]  ueCntAll  [NUM_CH];
  logic [ADDR_WIDTH-1:0] addrAll   [NUM_CH];
  logic [NUM_CH-1:0]     validAll;
  logic [NUM_CH-1:0]     alarmAll;

  for (genvar g = 0; g < NUM_CH; g++) begin : gChan
    logic [CNT_WIDTH-1:0]  ceCnt_q, ceCnt_d, ueCnt_q, ueCnt_d;
    logic [CNT_WIDTH-1:0]  ceBase, ueBase;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d, alarm_q, alarm_d;
    logic                  clrHit, validBase, alarmBase, alarmSet;

    // A same-cycle clear is applied to the "base" values before events, so
    // an event arriving with its own clear counts from zero.
    always_comb begin
      clrHit    = clear_req && (clear_sel == SEL_WIDTH'(g));
      ceBase    = clrHit ? '0 : ceCnt_q;
      ueBase    = clrHit ? '0 : ueCnt_q;
      validBase = clrHit ? 1'b0 : valid_q;
      alarmBase = clrHit ? 1'b0 : alarm_q;

      ceCnt_d = ceBase;
      if (ce_event[g] && (ceBase != CntMax)) ceCnt_d = ceBase + CNT_WIDTH'(1);
      ueCnt_d = ueBase;
      if (ue_event[g] && (ueBase != CntMax)) ueCnt_d = ueBase + CNT_WIDTH'(1);

      addr_d  = addr_q;
      valid_d = validBase;
      if ((ce_event[g] || ue_event[g]) && !validBase) begin
        addr_d  = event_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        valid_d = 1'b1;
      end

      alarmSet = ue_event[g]
              || (ce_event[g] && (ceBase != CntMax) && (ce_threshold != '0)
                  && (ceCnt_d == ce_threshold));
      alarm_d  = alarmSet || (alarmBase && !irq_ack[g]);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ceCnt_q <= '0;
        ueCnt_q <= '0;
        addr_q  <= '0;
        valid_q <= 1'b0;
        alarm_q <= 1'b0;
      end else begin
        ceCnt_q <= ceCnt_d;
        ueCnt_q <= ueCnt_d;
        addr_q  <= addr_d;
        valid_q <= valid_d;
        alarm_q <= alarm_d;
      end
    end

    assign ceCntAll[g] = ceCnt_q;
    assign ueCntAll[g] = ueCnt_q;
    assign addrAll[g]  = addr_q;
    assign validAll[g] = valid_q;
    assign alarmAll[g] = alarm_q;
  end

  logic [CNT_WIDTH-1:0]  rdCe_d, rdCe_q, rdUe_d, rdUe_q;
  logic [ADDR_WIDTH-1:0] rdAddr_d, rdAddr_q;
  logic                  rdValid_d, rdValid_q, rdSat_d, rdSat_q;

  // Out-of-range selects match no channel and therefore read zeros.
  always_comb begin
    rdCe_d    = '0;
    rdUe_d    = '0;
    rdAddr_d  = '0;
    rdValid_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_sel == SEL_WIDTH'(c)) begin
        rdCe_d    = ceCntAll[c];
        rdUe_d    = ueCntAll[c];
        rdAddr_d  = addrAll[c];
        rdValid_d = validAll[c];
      end
    end
    rdSat_d = (rdCe_d == CntMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdCe_q    <= '0;
      rdUe_q    <= '0;
      rdAddr_q  <= '0;
      rdValid_q <= 1'b0;
      rdSat_q   <= 1'b0;
    end else begin
      rdCe_q    <= rdCe_d;
      rdUe_q    <= rdUe_d;
      rdAddr_q  <= rdAddr_d;
      rdValid_q <= rdValid_d;
      rdSat_q   <= rdSat_d;
    end
  end

  assign ce_count_out    = rdCe_q;
  assign ue_count_out    = rdUe_q;
  assign first_addr_out  = rdAddr_q;
  assign first_valid_out = rdValid_q;
  assign ce_sat_out      = rdSat_q;
  assign alarm_pending   = alarmAll;
  assign irq             = |alarmAll;

endmodule

// File: tb/tb_memory_error_log_register.sv
// Scoreboard bench: a per-channel integer model predicts every cycle's read
// port and alarm state; a monitor compares one cycle after each stimulus.
module tb_memory_error_log_register;

  localparam int NCH  = 3;
  localparam int SW   = 2;
  localparam int CW   = 4;
  localparam int AW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    ce_event, ue_event, irq_ack;
  logic [NCH*AW-1:0] event_addr;
  logic [CW-1:0]     ce_threshold;
  logic              clear_req;
  logic [SW-1:0]     clear_sel, rd_sel;
  logic [CW-1:0]     ce_count_out, ue_count_out;
  logic [AW-1:0]     first_addr_out;
  logic              first_valid_out, ce_sat_out, irq;
  logic [NCH-1:0]    alarm_pending;

  memory_error_log_register #(
    .NUM_CH(NCH), .SEL_WIDTH(SW), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .ce_event(ce_event), .ue_event(ue_event),
    .event_addr(event_addr), .ce_threshold(ce_threshold),
    .clear_req(clear_req), .clear_sel(clear_sel), .irq_ack(irq_ack),
    .rd_sel(rd_sel), .ce_count_out(ce_count_out), .ue_count_out(ue_count_out),
    .first_addr_out(first_addr_out), .first_valid_out(first_valid_out),
    .ce_sat_out(ce_sat_out), .alarm_pending(alarm_pending), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ce;
    int         ue;
    logic [AW-1:0] addr;
    bit         fv;
    bit         sat;
    logic [NCH-1:0] alarm;
    bit         irq;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  int         ceM[NCH];
  int         ueM[NCH];
  logic [AW-1:0] addrM[NCH];
  bit         fvM[NCH];
  bit         alM[NCH];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the next edge.
  task automatic applyStimulus(input bit rst, input logic [NCH-1:0] ce, input logic [NCH-1:0] ue,
                               input logic [NCH*AW-1:0] addr, input int thr, input bit clr,
                               input int cs, input logic [NCH-1:0] ack, input int rs);
    exp_t e;
    bit   setA;
    @(negedge clk);
    reset = rst; ce_event = ce; ue_event = ue; event_addr = addr;
    ce_threshold = CW'(thr); clear_req = clr; clear_sel = SW'(cs);
    irq_ack = ack; rd_sel = SW'(rs);
    e.ce = 0; e.ue = 0; e.addr = '0; e.fv = 0; e.sat = 0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        ceM[c] = 0; ueM[c] = 0; addrM[c] = '0; fvM[c] = 0; alM[c] = 0;
      end
    end else begin
      if (rs < NCH) begin
        e.ce = ceM[rs]; e.ue = ueM[rs]; e.addr = addrM[rs]; e.fv = fvM[rs];
        e.sat = (ceM[rs] == CMAX);
      end
      for (int c = 0; c < NCH; c++) begin
        if (clr && cs == c) begin
          ceM[c] = 0; ueM[c] = 0; fvM[c] = 0; alM[c] = 0;
        end
        setA = 0;
        if (ce[c] && ceM[c] < CMAX) begin
          ceM[c]++;
          if (thr != 0 && ceM[c] == thr) setA = 1;
        end
        if (ue[c]) begin
          if (ueM[c] < CMAX) ueM[c]++;
          setA = 1;
        end
        if ((ce[c] || ue[c]) && !fvM[c]) begin
          fvM[c] = 1;
          addrM[c] = addr[c*AW +: AW];
        end
        alM[c] = setA ? 1'b1 : (ack[c] ? 1'b0 : alM[c]);
      end
    end
    e.irq = 0;
    for (int c = 0; c < NCH; c++) begin
      e.alarm[c] = alM[c];
      e.irq = e.irq | alM[c];
    end
    sbq.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("ce_count_out", 32'(ce_count_out), 32'(e.ce));
        checkOutput("ue_count_out", 32'(ue_count_out), 32'(e.ue));
        checkOutput("first_addr_out", 32'(first_addr_out), 32'(e.addr));
        checkOutput("first_valid_out", 32'(first_valid_out), 32'(e.fv));
        checkOutput("ce_sat_out", 32'(ce_sat_out), 32'(e.sat));
        checkOutput("alarm_pending", 32'(alarm_pending), 32'(e.alarm));
        checkOutput("irq", 32'(irq), 32'(e.irq));
      end
    end
  end

  function automatic logic [NCH*AW-1:0] addrOn(input int ch, input logic [AW-1:0] a);
    logic [NCH*AW-1:0] v;
    v = '0;
    v[ch*AW +: AW] = a;
    return v;
  endfunction

  initial begin
    logic [NCH*AW-1:0] ra;
    reset = 1'b1; ce_event = '0; ue_event = '0; event_addr = '0;
    ce_threshold = '0; clear_req = 1'b0; clear_sel = '0; irq_ack = '0; rd_sel = '0;

    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, i);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, i);

    applyStimulus(0, 3'b010, 0, addrOn(1, 16'h00A0), 0, 0, 0, 0, 1);
    applyStimulus(0, 3'b010, 0, addrOn(1, 16'h00B0), 0, 0, 0, 0, 1);
    applyStimulus(0, 3'b010, 0, addrOn(1, 16'h00C0), 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) applyStimulus(0, 3'b100, 0, addrOn(2, 16'h2200), 4, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 4, 0, 0, 3'b100, 2);
    applyStimulus(0, 0, 0, 0, 4, 0, 0, 0, 2);
    applyStimulus(0, 0, 3'b100, addrOn(2, 16'h2300), 4, 0, 0, 3'b100, 2);
    applyStimulus(0, 0, 0, 0, 4, 0, 0, 3'b100, 2);

    for (int i = 0; i < 20; i++) applyStimulus(0, 3'b001, 0, addrOn(0, 16'h0F00), 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 3'b010, 0, addrOn(1, 16'h1234), 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, i);

    applyStimulus(0, 3'b111, 3'b111, {16'h3333, 16'h2222, 16'h1111}, 2, 0, 0, 0, 1);
    applyStimulus(1, 3'b111, 3'b111, {16'h3333, 16'h2222, 16'h1111}, 2, 0, 0, 0, 1);
    applyStimulus(1, 3'b111, 3'b111, {16'h3333, 16'h2222, 16'h1111}, 2, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, i);

    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 63) == 0),
                    NCH'($urandom & $urandom), NCH'($urandom & $urandom & $urandom), ra,
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, CMAX),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    NCH'($urandom & $urandom), $urandom_range(0, 3));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_error_log_register.md
Name: memory_error_log_register

Overview:
Parametrised, multi-channel successor to the single correction counter. Tracks correctable (CE) and uncorrectable (UE) ECC events for NUM_CH memory channels. Each channel has saturating counters, first-error address capture and a threshold alarm. Alarms feed one sticky interrupt line, and one channel at a time is read out through a registered read port.

Parameters:
NUM_CH, 4, number of memory channels (1..16)
SEL_WIDTH, 2, width of channel select ports (must satisfy 2^SEL_WIDTH >= NUM_CH)
CNT_WIDTH, 16, width of each CE/UE counter
ADDR_WIDTH, 16, width of captured error address

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ce_event  input  NUM_CH  per-channel correctable-error pulse, one count per cycle high
ue_event  input  NUM_CH  per-channel uncorrectable-error pulse
event_addr  input  NUM_CH*ADDR_WIDTH  per-channel error address; channel c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH]
ce_threshold  input  CNT_WIDTH  CE alarm threshold, common to all channels; 0 disables CE alarms
clear_req  input  1  clear the channel named by clear_sel
clear_sel  input  SEL_WIDTH  channel to clear
irq_ack  input  NUM_CH  per-channel alarm acknowledge mask
rd_sel  input  SEL_WIDTH  channel to read
ce_count_out  output  CNT_WIDTH  CE count of the selected channel
ue_count_out  output  CNT_WIDTH  UE count of the selected channel
first_addr_out  output  ADDR_WIDTH  first captured error address of the selected channel
first_valid_out  output  1  first_addr_out holds a captured address
ce_sat_out  output  1  CE counter of the selected channel is saturated
alarm_pending  output  NUM_CH  sticky per-channel alarm bits
irq  output  1  OR of alarm_pending

Behaviour:
- Reset: all counters, addresses, valid flags and alarm_pending go to 0. All outputs read 0 on the cycle after reset is sampled high. Reset overrides every other input, including mid-burst events.
- Counters: on each clk edge with ce_event[c]=1, ce_cnt[c] increments by 1. It saturates at 2^CNT_WIDTH-1 and never wraps. ue_cnt[c] behaves the same with ue_event[c].
- ce_event[c] and ue_event[c] high in the same cycle increment both counters.
- All channels update independently and in parallel in the same cycle.
- First-error capture: if first_valid[c]=0 and (ce_event[c] | ue_event[c]), event_addr slice c is stored and first_valid[c] is set. Later events do not overwrite the stored address until the channel is cleared.
- Alarm set: alarm_pending[c] is set at the edge where the CE increment makes the next-state ce_cnt[c] equal ce_threshold. Only when ce_threshold != 0; a count already past the threshold does not re-trigger. Any ue_event[c] also sets alarm_pending[c]. Alarm bits are visible one cycle after the triggering event.
- Alarm clear: irq_ack[c]=1 clears alarm_pending[c]. If a new set condition occurs in the same cycle, set wins and the bit stays 1.
- irq is combinational OR of the alarm_pending registers, so it has no extra latency.
- Channel clear: clear_req=1 zeroes ce_cnt, ue_cnt, first_valid and alarm_pending of channel clear_sel. If clear_sel >= NUM_CH the request is ignored.
- Clear plus event on the same channel in the same cycle: the clear applies first, then the event. The counter ends at 1, the address is captured, and alarm rules are evaluated against the post-clear value.
- Read port: outputs are registered, one cycle of latency. At edge k they load the stored state of channel rd_sel as it stood before edge k's updates. rd_sel >= NUM_CH reads all zeros.
- ce_sat_out = 1 when the selected ce_cnt equals 2^CNT_WIDTH-1.

Test Plan:
- Reset then idle: hold reset 2 cycles, rd_sel=0..3 -> all count/address outputs 0, irq=0.
- CE counting: 3 single-cycle ce_event[1] pulses with addr 0x00A0, 0x00B0, 0x00C0; rd_sel=1 -> ce_count_out=3, ue_count_out=0, first_addr_out=0x00A0, first_valid_out=1; channel 0 still reads 0.
- Threshold/irq: ce_threshold=4, ce_event[2] held 6 cycles -> alarm_pending[2] rises one cycle after the 4th event, irq=1, no second trigger. irq_ack=4'b0100 drops irq. An ack coinciding with a ue_event[2] keeps the bit set.
- Saturation: CNT_WIDTH=4 build, ce_event[0] held 20 cycles -> ce_count_out stops at 15, ce_sat_out=1, no wrap to 0.
- Clear interactions: clear_req with clear_sel=1 and ce_event[1] in the same cycle with addr 0x1234 -> ce_count_out=1, first_addr_out=0x1234. clear_sel=3 with NUM_CH=3 leaves all channels unchanged.
- Reset mid-operation: reset asserted during simultaneous ce/ue bursts on all channels -> all state 0 next cycle, events during reset not counted.
